// File: rtl/decoder_pkg.sv
// decoder_pkg: shared widths and the one-hot decode function for the 3-to-8 decoder
package decoder_pkg;
  localparam int SEL_W = 3;
  localparam int NUM_OUT = 8;
  function automatic logic [NUM_OUT-1:0] onehot8(input logic [SEL_W-1:0] sel, input logic en);
    logic [NUM_OUT-1:0] one;
    one = {{(NUM_OUT-1){1'b0}}, 1'b1};
    return en ? one << sel : '0;
  endfunction
endpackage

// File: rtl/decoder3_8_core.sv
// decoder3_8_core: combinational decode, sel/en in, one-hot dec[7:0] out (all zero when en=0)
module decoder3_8_core
  import decoder_pkg::*;
(
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  output logic [NUM_OUT-1:0] dec
);
  always_comb dec = onehot8(sel, en);
endmodule

// File: rtl/decoder3_8_behavioral.sv
// decoder3_8_behavioral: registered 3-to-8 decoder; clk, rst_n (sync, active-low), en, A/B/C select (A=MSB) -> Y0..Y7, optional active-low outputs
module decoder3_8_behavioral
  import decoder_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic A,
  input  logic B,
  input  logic C,
  output logic Y0,
  output logic Y1,
  output logic Y2,
  output logic Y3,
  output logic Y4,
  output logic Y5,
  output logic Y6,
  output logic Y7
);
  localparam logic [NUM_OUT-1:0] INACTIVE = {NUM_OUT{OUT_ACTIVE_LOW}};
  logic [NUM_OUT-1:0] dec;
  logic [NUM_OUT-1:0] y_d;
  logic [NUM_OUT-1:0] y_q;
  decoder3_8_core u_core (
    .sel ({A, B, C}),
    .en  (en),
    .dec (dec)
  );
  always_comb y_d = dec ^ INACTIVE;
  always_ff @(posedge clk) begin
    if (!rst_n) y_q <= INACTIVE;
    else y_q <= y_d;
  end
  assign {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0} = y_q;
endmodule

// File: tb/tb_decoder3_8_behavioral.sv
// tb_decoder3_8_behavioral: scoreboard bench for both output polarities of the registered 3-to-8 decoder
module tb_decoder3_8_behavioral;
  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic [2:0] sel;
    logic [7:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic c = 1'b0;
  logic [7:0] yh;
  logic [7:0] yl;
  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  vec_t tbl [20];
  always #5 clk = ~clk;
  decoder3_8_behavioral #(.OUT_ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a), .B(b), .C(c),
    .Y0(yh[0]), .Y1(yh[1]), .Y2(yh[2]), .Y3(yh[3]),
    .Y4(yh[4]), .Y5(yh[5]), .Y6(yh[6]), .Y7(yh[7])
  );
  decoder3_8_behavioral #(.OUT_ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a), .B(b), .C(c),
    .Y0(yl[0]), .Y1(yl[1]), .Y2(yl[2]), .Y3(yl[3]),
    .Y4(yl[4]), .Y5(yl[5]), .Y6(yl[6]), .Y7(yl[7])
  );
  task automatic drive(input logic r, input logic e, input logic [2:0] s, input logic [7:0] x);
    @(negedge clk);
    rst_n = r;
    en = e;
    {a, b, c} = s;
    exp_q.push_back(x);
  endtask
  always @(posedge clk) begin
    logic [7:0] x;
    #1;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      checks++;
      if (yh !== x) begin
        failures++;
        $display("FAIL high_pol got=%b want=%b", yh, x);
      end
      checks++;
      if (yl !== ~x) begin
        failures++;
        $display("FAIL low_pol got=%b want=%b", yl, ~x);
      end
      checks++;
      if ($countones(yh) != ((x != 8'h00) ? 1 : 0)) begin
        failures++;
        $display("FAIL popcount got=%0d want=%0d", $countones(yh), (x != 8'h00) ? 1 : 0);
      end
    end
  end
  initial begin
    logic r, e;
    logic [2:0] s;
    tbl = '{
      {1'b0, 1'b1, 3'd5, 8'h00},
      {1'b0, 1'b1, 3'd5, 8'h00},
      {1'b1, 1'b1, 3'd5, 8'h20},
      {1'b1, 1'b0, 3'd1, 8'h00},
      {1'b1, 1'b0, 3'd1, 8'h00},
      {1'b1, 1'b1, 3'd0, 8'h01},
      {1'b1, 1'b1, 3'd1, 8'h02},
      {1'b1, 1'b1, 3'd2, 8'h04},
      {1'b1, 1'b1, 3'd3, 8'h08},
      {1'b1, 1'b1, 3'd4, 8'h10},
      {1'b1, 1'b1, 3'd5, 8'h20},
      {1'b1, 1'b1, 3'd6, 8'h40},
      {1'b1, 1'b1, 3'd7, 8'h80},
      {1'b1, 1'b1, 3'd0, 8'h01},
      {1'b0, 1'b1, 3'd7, 8'h00},
      {1'b1, 1'b1, 3'd7, 8'h80},
      {1'b1, 1'b1, 3'd3, 8'h08},
      {1'b0, 1'b1, 3'd3, 8'h00},
      {1'b1, 1'b0, 3'd3, 8'h00},
      {1'b1, 1'b1, 3'd6, 8'h40}
    };
    foreach (tbl[i]) drive(tbl[i].rst_n, tbl[i].en, tbl[i].sel, tbl[i].exp);
    for (int i = 0; i < 1000; i++) begin
      r = ($urandom_range(0, 19) != 0);
      e = $urandom_range(0, 1) == 1;
      s = 3'($urandom_range(0, 7));
      drive(r, e, s, (r && e) ? (8'h01 << s) : 8'h00);
    end
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
